// File: rtl/usb_pkg.sv
// Shared definitions for the USB device-mode transmit sequencer:
// received PID codes, transmit commands and sequencer states.
package usb_pkg;

    localparam logic [2:0] PidNone  = 3'd0;
    localparam logic [2:0] PidOut   = 3'd1;
    localparam logic [2:0] PidIn    = 3'd2;
    localparam logic [2:0] PidData0 = 3'd3;
    localparam logic [2:0] PidData1 = 3'd4;
    localparam logic [2:0] PidAck   = 3'd5;
    localparam logic [2:0] PidNak   = 3'd6;

    typedef enum logic [1:0] {
        TxNone = 2'b00,
        TxData = 2'b01,
        TxAck  = 2'b10,
        TxNak  = 2'b11
    } tx_cmd_t;

    typedef logic [2:0] seq_state_t;

    localparam seq_state_t StIdle     = 3'd0;
    localparam seq_state_t StOutWait  = 3'd1;
    localparam seq_state_t StTurn     = 3'd2;
    localparam seq_state_t StIssue    = 3'd3;
    localparam seq_state_t StTxActive = 3'd4;
    localparam seq_state_t StAckWait  = 3'd5;

    function automatic logic is_data_pid(input logic [2:0] pid);
        return (pid == PidData0) || (pid == PidData1);
    endfunction

endpackage

// File: rtl/seq_timer.sv
// Clearable up-counter that flags the last cycle before a programmable limit.
module seq_timer #(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [Width-1:0] limit,
    output logic             expired
);

    logic [Width-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_q <= '0;
        end else if (enable) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign expired = enable && (count_q == limit - 1'b1);

endmodule

// File: rtl/usb_tx_sequencer.sv
// Device-mode endpoint sequencer: decodes tokens/handshakes, tracks DATA toggles and
// issues DATA/ACK/NAK commands to the tx engine after a fixed bus turnaround.
module usb_tx_sequencer
    import usb_pkg::*;
#(
    parameter int unsigned TURNAROUND   = 16,
    parameter int unsigned RESP_TIMEOUT = 144
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_data_ready,
    input  logic [2:0] rx_packet,
    input  logic       rx_error,
    input  logic       tx_data_armed,
    input  logic [6:0] tx_byte_count,
    input  logic [6:0] buffer_occupancy,
    input  logic       tx_transfer_active,
    input  logic       tx_error,
    input  logic       clear_toggles,
    output logic [1:0] tx_packet,
    output logic       tx_pid_toggle,
    output logic       tx_done,
    output logic       flush,
    output logic       timeout,
    output logic       seq_busy
);

    localparam int unsigned MaxLimit = (TURNAROUND > RESP_TIMEOUT) ? TURNAROUND : RESP_TIMEOUT;
    localparam int unsigned TimerW   = $clog2(MaxLimit + 1);

    seq_state_t state_q, state_d;
    tx_cmd_t    resp_q, resp_d;
    tx_cmd_t    cmd_q, cmd_d;
    logic       seen_active_q, seen_active_d;
    logic       tx_tog_q, tx_tog_d;
    logic       rx_tog_q, rx_tog_d;
    logic       pid_tog_q, pid_tog_d;
    logic       done_q, done_d;
    logic       flush_q, flush_d;
    logic       timeout_q, timeout_d;

    logic              timer_en;
    logic              timer_expired;
    logic [TimerW-1:0] timer_limit;

    assign timer_en    = (state_q == StOutWait) || (state_q == StTurn) || (state_q == StAckWait);
    assign timer_limit = (state_q == StTurn) ? TimerW'(TURNAROUND) : TimerW'(RESP_TIMEOUT);

    // Any state change restarts the count, so every timed state begins at zero.
    seq_timer #(
        .Width (TimerW)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_d != state_q),
        .enable  (timer_en),
        .limit   (timer_limit),
        .expired (timer_expired)
    );

    always_comb begin
        state_d       = state_q;
        resp_d        = resp_q;
        seen_active_d = seen_active_q;
        tx_tog_d      = tx_tog_q;
        rx_tog_d      = rx_tog_q;
        cmd_d         = TxNone;
        pid_tog_d     = 1'b0;
        done_d        = 1'b0;
        flush_d       = 1'b0;
        timeout_d     = 1'b0;

        case (state_q)
            StIdle: begin
                if (rx_data_ready && !rx_error) begin
                    if (rx_packet == PidIn) begin
                        resp_d  = (tx_data_armed && (buffer_occupancy >= tx_byte_count)) ?
                                  TxData : TxNak;
                        state_d = StTurn;
                    end else if (rx_packet == PidOut) begin
                        state_d = StOutWait;
                    end
                end
            end
            StOutWait: begin
                if (rx_data_ready) begin
                    if (is_data_pid(rx_packet)) begin
                        if (rx_error) begin
                            flush_d = 1'b1;
                            state_d = StIdle;
                        end else begin
                            resp_d  = TxAck;
                            state_d = StTurn;
                            // A PID that does not match the expected toggle is a host retry.
                            if ((rx_packet == PidData1) == rx_tog_q) begin
                                rx_tog_d = ~rx_tog_q;
                            end else begin
                                flush_d = 1'b1;
                            end
                        end
                    end else begin
                        timeout_d = 1'b1;
                        state_d   = StIdle;
                    end
                end else if (timer_expired) begin
                    timeout_d = 1'b1;
                    state_d   = StIdle;
                end
            end
            StTurn: begin
                if (timer_expired) begin
                    state_d = StIssue;
                end
            end
            StIssue: begin
                cmd_d         = resp_q;
                pid_tog_d     = (resp_q == TxData) && tx_tog_q;
                seen_active_d = 1'b0;
                state_d       = StTxActive;
            end
            StTxActive: begin
                if (tx_error) begin
                    state_d = StIdle;
                end else if (tx_transfer_active) begin
                    seen_active_d = 1'b1;
                end else if (seen_active_q) begin
                    state_d = (resp_q == TxData) ? StAckWait : StIdle;
                end
            end
            StAckWait: begin
                if (rx_data_ready) begin
                    if ((rx_packet == PidAck) && !rx_error) begin
                        tx_tog_d = ~tx_tog_q;
                        done_d   = 1'b1;
                    end else begin
                        timeout_d = 1'b1;
                    end
                    state_d = StIdle;
                end else if (timer_expired) begin
                    timeout_d = 1'b1;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (clear_toggles) begin
            tx_tog_d = 1'b0;
            rx_tog_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            resp_q        <= TxNone;
            cmd_q         <= TxNone;
            seen_active_q <= 1'b0;
            tx_tog_q      <= 1'b0;
            rx_tog_q      <= 1'b0;
            pid_tog_q     <= 1'b0;
            done_q        <= 1'b0;
            flush_q       <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            resp_q        <= resp_d;
            cmd_q         <= cmd_d;
            seen_active_q <= seen_active_d;
            tx_tog_q      <= tx_tog_d;
            rx_tog_q      <= rx_tog_d;
            pid_tog_q     <= pid_tog_d;
            done_q        <= done_d;
            flush_q       <= flush_d;
            timeout_q     <= timeout_d;
        end
    end

    assign tx_packet     = cmd_q;
    assign tx_pid_toggle = pid_tog_q;
    assign tx_done       = done_q;
    assign flush         = flush_q;
    assign timeout       = timeout_q;
    assign seq_busy      = (state_q != StIdle);

endmodule

// File: tb/tb_usb_tx_sequencer.sv
// Randomized transaction-level bench for usb_tx_sequencer; expectations come from a
// toggle/latency model kept here.
module tb_usb_tx_sequencer;

    localparam logic [2:0] POut  = 3'd1;
    localparam logic [2:0] PIn   = 3'd2;
    localparam logic [2:0] PD0   = 3'd3;
    localparam logic [2:0] PD1   = 3'd4;
    localparam logic [2:0] PAck  = 3'd5;
    localparam logic [2:0] PNak  = 3'd6;
    localparam logic [1:0] CNone = 2'b00;
    localparam logic [1:0] CData = 2'b01;
    localparam logic [1:0] CAck  = 2'b10;
    localparam logic [1:0] CNak  = 2'b11;

    localparam int KAck      = 0;
    localparam int KTimeout  = 1;
    localparam int KBad      = 2;
    localparam int KAbort    = 3;
    localparam int KAckClear = 4;

    localparam int OGood    = 0;
    localparam int OBad     = 1;
    localparam int OTimeout = 2;
    localparam int OOther   = 3;

    logic       tb_clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_data_ready = 1'b0;
    logic [2:0] rx_packet = 3'd0;
    logic       rx_error = 1'b0;
    logic       tx_data_armed = 1'b0;
    logic [6:0] tx_byte_count = 7'd0;
    logic [6:0] buffer_occupancy = 7'd0;
    logic       tx_transfer_active = 1'b0;
    logic       tx_error = 1'b0;
    logic       clear_toggles = 1'b0;
    logic [1:0] tx_packet;
    logic       tx_pid_toggle;
    logic       tx_done;
    logic       flush;
    logic       timeout;
    logic       seq_busy;

    int n_checks = 0;
    int n_pass   = 0;
    bit m_tx_tog = 1'b0;
    bit m_rx_tog = 1'b0;

    usb_tx_sequencer dut (
        .clk                (tb_clk),
        .rst                (rst),
        .rx_data_ready      (rx_data_ready),
        .rx_packet          (rx_packet),
        .rx_error           (rx_error),
        .tx_data_armed      (tx_data_armed),
        .tx_byte_count      (tx_byte_count),
        .buffer_occupancy   (buffer_occupancy),
        .tx_transfer_active (tx_transfer_active),
        .tx_error           (tx_error),
        .clear_toggles      (clear_toggles),
        .tx_packet          (tx_packet),
        .tx_pid_toggle      (tx_pid_toggle),
        .tx_done            (tx_done),
        .flush              (flush),
        .timeout            (timeout),
        .seq_busy           (seq_busy)
    );

    always #5 tb_clk = ~tb_clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge tb_clk);
        @(negedge tb_clk);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) step();
    endtask

    task automatic send_token(input logic [2:0] pid, input logic err);
        rx_data_ready = 1'b1;
        rx_packet     = pid;
        rx_error      = err;
        step();
        rx_data_ready = 1'b0;
        rx_packet     = 3'd0;
        rx_error      = 1'b0;
        clear_toggles = 1'b0;
    endtask

    // Command must appear exactly TURNAROUND+1 cycles after the sampled token, for one cycle.
    task automatic expect_cmd(input logic [1:0] cmd, input logic tog);
        int early = 0;
        repeat (16) begin
            step();
            if (tx_packet != CNone) early++;
        end
        check_eq("cmd_early", early, 0);
        step();
        check_eq("cmd", tx_packet, cmd);
        if (cmd == CData) check_eq("pid_toggle", tx_pid_toggle, tog);
        step();
        check_eq("cmd_one_cycle", tx_packet, CNone);
    endtask

    task automatic expect_timeout();
        int early = 0;
        repeat (143) begin
            step();
            if (timeout || tx_packet != CNone) early++;
        end
        check_eq("timeout_early", early, 0);
        step();
        check_eq("timeout", timeout, 1);
        check_eq("idle_after_timeout", seq_busy, 0);
    endtask

    task automatic run_tx(input int active_len, input bit abort);
        tx_transfer_active = 1'b1;
        idle_cycles(active_len);
        if (abort) begin
            tx_error = 1'b1;
            step();
            tx_error = 1'b0;
        end
        tx_transfer_active = 1'b0;
        step();
    endtask

    task automatic do_in(input bit armed, input int cnt, input int occ, input int kind,
                         input int delay);
        logic [1:0] exp_cmd;
        tx_data_armed    = armed;
        tx_byte_count    = 7'(cnt);
        buffer_occupancy = 7'(occ);
        exp_cmd = (armed && occ >= cnt) ? CData : CNak;
        send_token(PIn, 1'b0);
        check_eq("busy_turn", seq_busy, 1);
        expect_cmd(exp_cmd, m_tx_tog);
        run_tx(1 + $urandom_range(0, 3), kind == KAbort);
        if (kind == KAbort || exp_cmd == CNak) begin
            check_eq("idle_after_tx", seq_busy, 0);
            return;
        end
        check_eq("busy_ack_wait", seq_busy, 1);
        case (kind)
            KAck, KAckClear: begin
                idle_cycles(delay);
                if (kind == KAckClear) clear_toggles = 1'b1;
                send_token(PAck, 1'b0);
                check_eq("tx_done", tx_done, 1);
                check_eq("no_timeout_on_ack", timeout, 0);
                if (kind == KAckClear) begin
                    m_tx_tog = 1'b0;
                    m_rx_tog = 1'b0;
                end else begin
                    m_tx_tog = ~m_tx_tog;
                end
            end
            KTimeout: expect_timeout();
            default: begin
                idle_cycles(delay);
                case ($urandom_range(0, 2))
                    0: send_token(PAck, 1'b1);
                    1: send_token(PNak, 1'b0);
                    default: send_token(PD0, 1'b0);
                endcase
                check_eq("bad_ack_timeout", timeout, 1);
                check_eq("bad_ack_no_done", tx_done, 0);
            end
        endcase
        check_eq("idle_after_in", seq_busy, 0);
    endtask

    task automatic do_out(input int kind, input bit pid, input int delay);
        int stray = 0;
        bit exp_flush;
        send_token(POut, 1'b0);
        check_eq("busy_out_wait", seq_busy, 1);
        case (kind)
            OTimeout: expect_timeout();
            OOther: begin
                idle_cycles(delay);
                send_token(PIn, 1'b0);
                check_eq("out_other_timeout", timeout, 1);
                check_eq("out_other_no_flush", flush, 0);
                check_eq("out_other_idle", seq_busy, 0);
            end
            OBad: begin
                idle_cycles(delay);
                send_token(pid ? PD1 : PD0, 1'b1);
                check_eq("bad_data_flush", flush, 1);
                check_eq("bad_data_idle", seq_busy, 0);
                repeat (20) begin
                    step();
                    if (tx_packet != CNone) stray++;
                end
                check_eq("bad_data_no_cmd", stray, 0);
            end
            default: begin
                idle_cycles(delay);
                exp_flush = (pid != m_rx_tog);
                send_token(pid ? PD1 : PD0, 1'b0);
                check_eq("out_flush", flush, exp_flush);
                if (!exp_flush) m_rx_tog = ~m_rx_tog;
                expect_cmd(CAck, 1'b0);
                run_tx(1 + $urandom_range(0, 3), 1'b0);
                check_eq("idle_after_out", seq_busy, 0);
            end
        endcase
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_cmd"}, tx_packet, CNone);
        check_eq({tag, "_tog"}, tx_pid_toggle, 0);
        check_eq({tag, "_done"}, tx_done, 0);
        check_eq({tag, "_flush"}, flush, 0);
        check_eq({tag, "_timeout"}, timeout, 0);
        check_eq({tag, "_busy"}, seq_busy, 0);
    endtask

    initial begin
        int op;
        int cnt;
        int occ;
        @(negedge tb_clk);
        idle_cycles(3);
        rst = 1'b0;
        check_all_zero("reset");

        // Plan 1: DATA0 then DATA1 after ACK
        do_in(1'b1, 4, 4, KAck, 10);
        do_in(1'b1, 4, 4, KAck, 5);
        // Plan 2: buffer short gives NAK
        do_in(1'b1, 4, 3, KAck, 0);
        // Boundaries: zero length, unarmed, full range
        do_in(1'b1, 0, 0, KAck, 2);
        do_in(1'b0, 0, 5, KAck, 0);
        do_in(1'b1, 127, 127, KAck, 1);
        // Errored IN token is ignored
        send_token(PIn, 1'b1);
        check_eq("err_token_ignored", seq_busy, 0);
        // Plan 3: OUT DATA0 then retry
        do_out(OGood, 1'b0, 5);
        do_out(OGood, 1'b0, 5);
        // Plan 4: bad data, missing data
        do_out(OBad, 1'b1, 3);
        do_out(OTimeout, 1'b0, 0);
        // Plan 5: missing ACK keeps toggle, then resend
        do_in(1'b1, 4, 4, KTimeout, 0);
        do_in(1'b1, 4, 4, KAck, 0);
        do_in(1'b1, 4, 4, KAbort, 0);

        // Plan 6: reset during TX_ACTIVE
        tx_data_armed    = 1'b1;
        tx_byte_count    = 7'd4;
        buffer_occupancy = 7'd4;
        send_token(PIn, 1'b0);
        expect_cmd(CData, m_tx_tog);
        tx_transfer_active = 1'b1;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        tx_transfer_active = 1'b0;
        check_all_zero("mid_tx_reset");
        m_tx_tog = 1'b0;
        m_rx_tog = 1'b0;
        do_in(1'b1, 4, 4, KAck, 1);
        do_in(1'b1, 4, 4, KAckClear, 3);
        do_in(1'b1, 4, 4, KAck, 0);

        for (int i = 0; i < 30; i++) begin
            op = $urandom_range(0, 9);
            if (op <= 4) begin
                cnt = $urandom_range(0, 127);
                if ($urandom_range(0, 1) == 1) occ = $urandom_range(0, 127);
                else occ = cnt + $urandom_range(0, 4) - 2;
                if (occ < 0) occ = 0;
                if (occ > 127) occ = 127;
                do_in($urandom_range(0, 3) != 0, cnt, occ, $urandom_range(0, 4),
                      $urandom_range(0, 60));
            end else if (op <= 8) begin
                do_out($urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom_range(0, 60));
            end else begin
                clear_toggles = 1'b1;
                step();
                clear_toggles = 1'b0;
                m_tx_tog = 1'b0;
                m_rx_tog = 1'b0;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/usb_tx_sequencer.md
# usb_tx_sequencer

Endpoint-level controller that sequences the USB `tx` packet engine in device mode. It decodes tokens and handshakes reported by the receive path and decides whether to command `tx` to send DATA, ACK or NAK, after a fixed bus turnaround. It tracks the DATA0/DATA1 toggle for both directions and times out missing host responses. It sits between the receiver, the shared packet buffer status and the `tx` block's `tx_packet` command input.

## Interface
- TURNAROUND, 16: idle clocks between the end of a received packet and the issued `tx_packet` command.
- RESP_TIMEOUT, 144: clocks allowed for the host's next packet (DATA after OUT, ACK after our DATA).
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- rx_data_ready  in  1  one-cycle pulse; `rx_packet` is valid in this cycle.
- rx_packet  in  3  received PID code: 0 none, 1 OUT, 2 IN, 3 DATA0, 4 DATA1, 5 ACK, 6 NAK.
- rx_error  in  1  the receiver flagged the current packet as bad; sampled with `rx_data_ready`.
- tx_data_armed  in  1  level; software has a packet queued for IN.
- tx_byte_count  in  7  byte count of the queued packet.
- buffer_occupancy  in  7  current fill level of the shared buffer.
- tx_transfer_active  in  1  from `tx`; high while a packet is on the bus.
- tx_error  in  1  from `tx`; the transmit was aborted.
- clear_toggles  in  1  pulse; resets both toggles to 0.
- tx_packet  out  2  command to `tx`: 00 none, 01 DATA, 10 ACK, 11 NAK. A nonzero value lasts exactly one cycle.
- tx_pid_toggle  out  1  0 selects DATA0, 1 selects DATA1. Valid whenever `tx_packet` = DATA.
- tx_done  out  1  pulse; the host ACKed our DATA.
- flush  out  1  pulse; discard the buffer contents (bad or duplicate OUT data).
- timeout  out  1  pulse; the expected host packet did not arrive.
- seq_busy  out  1  high in every state except IDLE.

## Operation
- **Reset values:** all outputs are 0, the state is IDLE and both toggles (`tx_tog`, `rx_tog`) are 0. Reset taken in any state aborts the operation with no pulses.
- **IDLE**
  - IN: if `tx_data_armed` and `buffer_occupancy` ≥ `tx_byte_count`, latch resp=DATA; otherwise resp=NAK. Go to TURN.
  - OUT: go to OUT_WAIT; the timer starts.
  - Any other PID, and `rx_error` on an IN or OUT token, is ignored; the state stays IDLE.
- **OUT_WAIT**
  - DATA0/1 with `rx_error`: pulse `flush`, go to IDLE with no response.
  - DATA PID bit equal to `rx_tog`: resp=ACK, flip `rx_tog`, go to TURN.
  - DATA PID bit not equal to `rx_tog` (retransmission): resp=ACK, pulse `flush`, leave `rx_tog` unchanged, go to TURN.
  - Any other PID, or timer expiry: pulse `timeout`, go to IDLE.
- **TURN:** wait TURNAROUND cycles, then go to ISSUE.
- **ISSUE:** drive `tx_packet`=resp for one cycle; `tx_pid_toggle`=`tx_tog`. Go to TX_ACTIVE.
- **TX_ACTIVE:** wait for `tx_transfer_active` to go 1 and then back to 0.
  - `tx_error` seen at any point: go to IDLE with no toggle change and no response wait.
  - Normal completion with resp=DATA: go to ACK_WAIT; the timer starts.
  - Normal completion otherwise: go to IDLE.
- **ACK_WAIT**
  - ACK without `rx_error`: flip `tx_tog`, pulse `tx_done`, go to IDLE.
  - Any other packet, or timer expiry: pulse `timeout`, go to IDLE. `tx_tog` is kept so the host's retry resends the same PID.
- **Timer**
  - Cleared on entry to OUT_WAIT, ACK_WAIT and TURN; increments every cycle in those states.
  - Expiry condition: count = limit−1 with no `rx_data_ready` in the same cycle.
  - Width is $clog2(max(TURNAROUND, RESP_TIMEOUT)+1).
- **Simultaneous events:** `rx_data_ready` beats timer expiry. `clear_toggles` beats a toggle flip in the same cycle.
- **Compare widths:** `buffer_occupancy` and `tx_byte_count` are compared unsigned at 7 bits. A count of 0 with `tx_data_armed` sends a zero-length DATA packet.

## Timing
- **Command latency:** `rx_data_ready` for IN/OUT-DATA sampled at edge T → `tx_packet` nonzero in cycle T+TURNAROUND+1 (T+17 at the default).
- **Response timeout:** `timeout` pulses RESP_TIMEOUT cycles after entry to OUT_WAIT or ACK_WAIT.
- **Pulse alignment:** `tx_done`, `flush` and `timeout` are registered one-cycle pulses, asserted in the cycle after the causing sample.
- **Output registration:** `tx_packet` and `tx_pid_toggle` come from flops, with no combinational path from inputs.
- **Toggle timing:** flips take effect in the cycle after the event.

## Structure
- Shared package `usb_pkg` holds:
  - the `rx_packet` code constants;
  - the `tx_packet` command enum;
  - the state enum (IDLE, OUT_WAIT, TURN, ISSUE, TX_ACTIVE, ACK_WAIT).
- One sub-module, `seq_timer`: a clearable up-counter with a limit input and an expiry flag, instanced once. It is shared across TURN and the response waits by muxing the limit.

## Test plan
1. **IN, data ready:** reset; `tx_data_armed`=1, `tx_byte_count`=4, `buffer_occupancy`=4; IN pulse at T → `tx_packet`=01 at T+17 with `tx_pid_toggle`=0. `tx` completes; ACK arrives → `tx_done` pulse, next DATA uses toggle 1.
2. **IN, buffer short:** IN with `buffer_occupancy`=3 < `tx_byte_count`=4 → `tx_packet`=11 (NAK) at T+17; toggle unchanged, `tx_done` never asserted.
3. **OUT + DATA0, then retry:** OUT + DATA0 → ACK (10), `rx_tog`=1. A second OUT + DATA0 → ACK plus a `flush` pulse, `rx_tog` stays 1.
4. **Bad OUT data / missing DATA:** OUT, then DATA1 with `rx_error` → `flush` pulse, no `tx_packet`. OUT followed by no packet → `timeout` exactly 144 cycles after OUT, state IDLE.
5. **Missing host ACK:** DATA sent, no ACK → `timeout` at 144 cycles, `tx_tog` still 0. The next IN resends DATA0.
6. **Reset and clear:** `rst` asserted in TX_ACTIVE → next cycle all outputs 0, `seq_busy`=0. `clear_toggles` in the same cycle as an ACK in ACK_WAIT → `tx_tog`=0 afterwards.
